// File: rtl/formula_task_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : formula_task_scheduler
// Brief    : Round-robin dispatch of argument triples to a pool of formula
//            units, with result capture and strictly in-order retirement.
// Revision : 1.0
// ============================================================================
module formula_task_scheduler #(
  parameter int N_UNITS = 4,
  parameter int W       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arg_vld,
  output logic                         arg_rdy,
  input  logic [W-1:0]                 a,
  input  logic [W-1:0]                 b,
  input  logic [W-1:0]                 c,
  output logic [N_UNITS-1:0]           unit_arg_vld,
  output logic [W-1:0]                 unit_a,
  output logic [W-1:0]                 unit_b,
  output logic [W-1:0]                 unit_c,
  input  logic [N_UNITS-1:0]           unit_res_vld,
  input  logic [N_UNITS*W-1:0]         unit_res,
  output logic                         res_vld,
  input  logic                         res_rdy,
  output logic [W-1:0]                 res,
  output logic [$clog2(N_UNITS+1)-1:0] in_flight,
  output logic                         proto_err
);

  localparam int c_idx_w = $clog2(N_UNITS);
  localparam int c_cnt_w = $clog2(N_UNITS + 1);
  localparam logic [N_UNITS-1:0] c_one = {{(N_UNITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } unit_state_t;

  unit_state_t          r_state [N_UNITS];
  logic [W-1:0]         r_slot  [N_UNITS];
  logic [c_idx_w-1:0]   r_fifo  [N_UNITS];
  logic [c_idx_w-1:0]   r_rd;
  logic [c_idx_w-1:0]   r_wr;
  logic [c_idx_w-1:0]   r_rr;
  logic [c_cnt_w-1:0]   r_count;

  logic [N_UNITS-1:0]   w_idle;
  logic [c_cnt_w-1:0]   w_busy_cnt;
  logic [c_idx_w-1:0]   w_sel;
  logic [c_idx_w-1:0]   w_head;
  logic                 w_accept;
  logic                 w_retire;

  function automatic logic [c_idx_w-1:0] next_idx(input logic [c_idx_w-1:0] i);
    return (i == c_idx_w'(N_UNITS - 1)) ? '0 : i + c_idx_w'(1);
  endfunction

  always_comb begin
    w_idle     = '0;
    w_busy_cnt = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      w_idle[k]  = (r_state[k] == S_IDLE);
      w_busy_cnt = w_busy_cnt + c_cnt_w'(r_state[k] != S_IDLE);
    end
  end

  // Scan from the farthest candidate back to rr so the nearest idle unit wins.
  always_comb begin
    w_sel = r_rr;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      logic [c_idx_w:0] j;
      j = {1'b0, r_rr} + (c_idx_w+1)'(i);
      if (j >= (c_idx_w+1)'(N_UNITS)) j = j - (c_idx_w+1)'(N_UNITS);
      if (w_idle[j[c_idx_w-1:0]]) w_sel = j[c_idx_w-1:0];
    end
  end

  assign w_head    = r_fifo[r_rd];
  assign arg_rdy   = |w_idle;
  assign w_accept  = arg_vld && arg_rdy;
  assign res_vld   = (r_count != '0) && (r_state[w_head] == S_DONE);
  assign w_retire  = res_vld && res_rdy;
  assign res       = r_slot[w_head];
  assign in_flight = w_busy_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_UNITS; k++) begin
        r_state[k] <= S_IDLE;
        r_slot[k]  <= '0;
        r_fifo[k]  <= '0;
      end
      r_rd         <= '0;
      r_wr         <= '0;
      r_rr         <= '0;
      r_count      <= '0;
      unit_arg_vld <= '0;
      unit_a       <= '0;
      unit_b       <= '0;
      unit_c       <= '0;
      proto_err    <= 1'b0;
    end else begin
      unit_arg_vld <= w_accept ? (c_one << w_sel) : '0;
      if (w_accept) begin
        unit_a       <= a;
        unit_b       <= b;
        unit_c       <= c;
        r_fifo[r_wr] <= w_sel;
        r_wr         <= next_idx(r_wr);
        r_rr         <= next_idx(w_sel);
      end
      if (w_retire) r_rd <= next_idx(r_rd);
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      // Dispatch needs IDLE, retire needs DONE, capture needs BUSY: mutually exclusive.
      for (int k = 0; k < N_UNITS; k++) begin
        if (w_accept && (w_sel == c_idx_w'(k))) begin
          r_state[k] <= S_BUSY;
        end else if (w_retire && (w_head == c_idx_w'(k))) begin
          r_state[k] <= S_IDLE;
        end else if (unit_res_vld[k] && (r_state[k] == S_BUSY)) begin
          r_state[k] <= S_DONE;
          r_slot[k]  <= unit_res[k*W +: W];
        end
        if (unit_res_vld[k] && (r_state[k] != S_BUSY)) proto_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_formula_task_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_formula_task_scheduler
// Brief    : Self-checking bench with emulated a+b+c units of programmable
//            latency and an in-order result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_formula_task_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           arg_vld = 1'b0;
  logic           arg_rdy;
  logic [W-1:0]   a = '0, b = '0, c = '0;
  logic [N-1:0]   unit_arg_vld;
  logic [W-1:0]   unit_a, unit_b, unit_c;
  logic [N-1:0]   unit_res_vld;
  logic [N-1:0]   emu_vld = '0;
  logic [N-1:0]   inject = '0;
  logic [N*W-1:0] unit_res = '0;
  logic           res_vld;
  logic           res_rdy = 1'b1;
  logic [W-1:0]   res;
  logic [CW-1:0]  in_flight;
  logic           proto_err;

  int             ntests = 0;
  int             nfail  = 0;
  int             lat [N] = '{default: 5};
  int             cnt [N] = '{default: 0};
  logic [W-1:0]   val [N];
  int             start_unit [$];
  int             start_edge [$];
  logic [W-1:0]   exp_q [$];
  logic           perr_model = 1'b0;
  logic           hold_prev = 1'b0;
  logic [W-1:0]   res_prev = '0;

  always #5 clk = ~clk;

  assign unit_res_vld = emu_vld | inject;

  formula_task_scheduler #(.N_UNITS(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
    .unit_arg_vld(unit_arg_vld), .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c),
    .unit_res_vld(unit_res_vld), .unit_res(unit_res),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
    .in_flight(in_flight), .proto_err(proto_err)
  );

  // Index of the most recent rising edge (posedges at 5, 15, 25, ...).
  function automatic int last_edge();
    return int'(($time - 5) / 10);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Unit emulation: a start seen in a cycle answers a+b+c L cycles later.
  always @(negedge clk) begin
    emu_vld = '0;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cnt[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (cnt[k] > 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin
            emu_vld[k] = 1'b1;
            unit_res[k*W +: W] = val[k];
          end
        end
        if (unit_arg_vld[k]) begin
          cnt[k] = lat[k];
          val[k] = unit_a + unit_b + unit_c;
          start_unit.push_back(k);
          start_edge.push_back(last_edge());
        end
      end
    end
  end

  // Scoreboard: outstanding tasks in acceptance order, compared every cycle.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      perr_model = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      chk("in_flight", in_flight, exp_q.size());
      chk("arg_rdy", arg_rdy, exp_q.size() < N);
      chk("proto_err", proto_err, perr_model);
      if (hold_prev) begin
        chk("hold_vld", res_vld, 1);
        chk("hold_res", res, res_prev);
      end
      if (res_vld) begin
        if (exp_q.size() == 0) chk("stale_res_vld", res_vld, 0);
        else begin
          chk("res_order", res, exp_q[0]);
          if (res_rdy) void'(exp_q.pop_front());
        end
      end
      hold_prev = res_vld && !res_rdy;
      res_prev  = res;
      if (arg_vld && arg_rdy) exp_q.push_back(a + b + c);
      if (|inject) perr_model = 1'b1;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z, output int e);
    int n = 0;
    arg_vld = 1'b1; a = x; b = y; c = z;
    while (!arg_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = -1;
    if (!arg_rdy) chk("send_timeout", arg_rdy, 1);
    else begin
      @(posedge clk);
      e = last_edge();
    end
    @(negedge clk);
    arg_vld = 1'b0;
  endtask

  task automatic wait_res(output int e);
    int n = 0;
    while (!res_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_res_timeout", res_vld, 1);
    e = last_edge();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((in_flight != '0 || res_vld) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", in_flight, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; arg_vld = 1'b0; inject = '0; res_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_unit.delete();
    start_edge.delete();
    for (int k = 0; k < N; k++) lat[k] = 5;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [5];
    int e1;
    logic seen;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_arg_rdy", arg_rdy, 1);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_unit_arg_vld", unit_arg_vld, 0);
    chk("rst_unit_a", unit_a, 0);
    chk("rst_res", res, 0);
    chk("rst_proto_err", proto_err, 0);

    // Single task, latency 5
    @(negedge clk);
    send(1, 2, 3, acc[0]);
    wait_res(e1);
    chk("t1_latency", e1 - acc[0], 6);
    chk("t1_res", res, 6);
    chk("t1_in_flight_busy", in_flight, 1);
    @(negedge clk);
    chk("t1_in_flight_idle", in_flight, 0);
    chk("t1_res_vld_low", res_vld, 0);
    chk("t1_nstart", start_unit.size(), 1);
    if (start_unit.size() > 0) begin
      chk("t1_unit", start_unit[0], 0);
      chk("t1_start_edge", start_edge[0] - acc[0], 0);
    end

    // Round-robin: four back-to-back, fifth stalls until the first retire
    do_reset();
    for (int i = 0; i < 4; i++) send(W'(10 * i + 1), 2, 3, acc[i]);
    send(7, 7, 7, acc[4]);
    chk("t2_fifth_accept", acc[4] - acc[0], 8);
    for (int i = 1; i < 4; i++) chk("t2_back_to_back", acc[i] - acc[0], i);
    wait_idle();
    chk("t2_nstart", start_unit.size(), 5);
    for (int i = 0; i < 5 && i < start_unit.size(); i++) begin
      chk("t2_unit", start_unit[i], i % 4);
      chk("t2_start_edge", start_edge[i] - acc[i], 0);
    end

    // Out-of-order completion held back behind the head
    do_reset();
    lat[0] = 9;
    lat[1] = 2;
    send(10, 20, 30, acc[0]);
    send(1, 1, 1, acc[1]);
    repeat (4) @(negedge clk);
    chk("t3_blocked_res_vld", res_vld, 0);
    chk("t3_in_flight", in_flight, 2);
    wait_res(e1);
    chk("t3_latency", e1 - acc[0], 10);
    chk("t3_res0", res, 60);
    @(negedge clk);
    chk("t3_res_vld1", res_vld, 1);
    chk("t3_res1", res, 3);
    @(negedge clk);
    chk("t3_res_vld_end", res_vld, 0);

    // Backpressure: hold for 20 cycles, then four retires in four cycles
    do_reset();
    res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(W'(100 + i), 0, 0, acc[i]);
    repeat (20) @(negedge clk);
    chk("t4_res_vld", res_vld, 1);
    chk("t4_res", res, 100);
    chk("t4_arg_rdy", arg_rdy, 0);
    chk("t4_in_flight", in_flight, 4);
    res_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_vld", res_vld, 1);
      chk("t4_drain_res", res, 100 + i);
      @(negedge clk);
    end
    chk("t4_in_flight_end", in_flight, 0);
    chk("t4_res_vld_end", res_vld, 0);

    // Unexpected result on an idle unit
    do_reset();
    @(negedge clk);
    inject = 4'b0100;
    @(negedge clk);
    inject = '0;
    #1;
    chk("t5_proto_err", proto_err, 1);
    repeat (5) @(negedge clk);
    chk("t5_proto_err_sticky", proto_err, 1);

    // Asynchronous reset with three tasks in flight
    do_reset();
    for (int i = 0; i < 3; i++) send(W'(5 + i), 1, 1, acc[i]);
    chk("t6_in_flight_pre", in_flight, 3);
    chk("t6_unit_arg_vld_pre", unit_arg_vld, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_res_vld", res_vld, 0);
    chk("t6_rst_in_flight", in_flight, 0);
    chk("t6_rst_unit_arg_vld", unit_arg_vld, 0);
    chk("t6_rst_unit_a", unit_a, 0);
    chk("t6_rst_res", res, 0);
    chk("t6_rst_arg_rdy", arg_rdy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | res_vld;
    end
    chk("t6_no_stale_res_vld", seen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
